// File: rtl/axi_write_response_gen.sv
// AXI slave write-response (B channel) generator: in-order completion FIFO feeding registered B outputs.
// Optional saturating handshake statistics enabled by defining AXI_WRITE_RESPONSE_GEN_STATS_EN.
module axi_write_response_gen #(
  parameter int unsigned AXI_BID_WIDTH   = 1,
  parameter int unsigned AXI_BUSER_WIDTH = 1,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AXI_BID_WIDTH-1:0]   req_id,
  input  logic [1:0]                 req_resp,
  input  logic [AXI_BUSER_WIDTH-1:0] req_user,
  output logic [AXI_BID_WIDTH-1:0]   bid,
  output logic [1:0]                 bresp,
  output logic [AXI_BUSER_WIDTH-1:0] buser,
  output logic                       bvalid,
  input  logic                       bready,
`ifdef AXI_WRITE_RESPONSE_GEN_STATS_EN
  output logic [15:0]                stat_ok,
  output logic [15:0]                stat_err,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [AXI_BID_WIDTH-1:0]   id;
    logic [1:0]                 resp;
    logic [AXI_BUSER_WIDTH-1:0] user;
  } rec_t;

  rec_t          r_mem [DEPTH];
  rec_t          r_b;
  logic          r_bvalid;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_mem_cnt;
  logic          w_mem_empty;
  logic          w_load;
  logic          w_bypass;
  logic          w_wr;
  logic          w_rd;
  rec_t          w_req_rec;

  // level counts the presented record too, so the memory holds level minus bvalid entries
  assign req_ready   = (r_level < LW'(DEPTH));
  assign w_push      = req_valid && req_ready;
  assign w_pop       = r_bvalid && bready;
  assign w_mem_cnt   = r_level - LW'(r_bvalid);
  assign w_mem_empty = (w_mem_cnt == '0);
  assign w_load      = (!r_bvalid || w_pop) && (!w_mem_empty || w_push);
  assign w_bypass    = w_load && w_mem_empty;
  assign w_wr        = w_push && !w_bypass;
  assign w_rd        = w_load && !w_mem_empty;

  always_comb begin
    w_req_rec      = '0;
    w_req_rec.id   = req_id;
    w_req_rec.resp = req_resp;
    w_req_rec.user = req_user;
  end

  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_req_rec;
    end
  end

  // Pointers, occupancy and the B-channel holding register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_bvalid <= 1'b0;
      r_b      <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_load) begin
        r_bvalid <= 1'b1;
        r_b      <= w_bypass ? w_req_rec : r_mem[r_rptr];
      end else if (w_pop) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign bid    = r_b.id;
  assign bresp  = r_b.resp;
  assign buser  = r_b.user;
  assign bvalid = r_bvalid;
  assign level  = r_level;

`ifdef AXI_WRITE_RESPONSE_GEN_STATS_EN
  logic [15:0] r_stat_ok;
  logic [15:0] r_stat_err;

  // SLVERR/DECERR both have resp[1] set
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_ok  <= '0;
      r_stat_err <= '0;
    end else if (w_pop) begin
      if (r_b.resp[1]) begin
        if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
      end else begin
        if (r_stat_ok != 16'hFFFF) r_stat_ok <= r_stat_ok + 16'd1;
      end
    end
  end

  assign stat_ok  = r_stat_ok;
  assign stat_err = r_stat_err;
`endif

endmodule
